// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, mispredict flush sequencing,
// external memory freeze and a post-reset boot window, plus a stall counter.
module hazard_ctrl_unit #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned BOOT_CYC  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_ex_mem_read,
  input  logic [REG_W-1:0]         id_ex_rd,
  input  logic [NUM_SRC*REG_W-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]       if_id_rs_used,
  input  logic                     mispredict,
  input  logic                     ext_stall,
  output logic                     stall_pc,
  output logic                     stall_if_id,
  output logic                     bubble_id_ex,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic                     pred_hold,
  output logic [2:0]               state_o,
  output logic [CNT_W-1:0]         stall_count
);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LSTALL = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FREEZE = 3'd4
  } state_e;

  // A zero-length boot window means the first cycle out of reset is already RUN.
  localparam state_e     RST_ST    = (BOOT_CYC == 0) ? ST_RUN : ST_BOOT;
  localparam logic [2:0] BOOT_INIT = 3'(BOOT_CYC);
  localparam logic [2:0] LAT_M1    = 3'(LOAD_LAT - 1);
  localparam logic [1:0] FL_M1     = 2'(FLUSH_CYC - 1);
  localparam logic [1:0] FL_FULL   = 2'(FLUSH_CYC);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [2:0]       boot_q, boot_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       flush_rem;
  logic             src_hit;
  logic             hazard;

  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (if_id_rs_used[i] && (if_id_rs[i*REG_W +: REG_W] == id_ex_rd)) src_hit = 1'b1;
    end
  end

  assign hazard = id_ex_mem_read && (id_ex_rd != '0) && src_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ST;
      ret_q   <= ST_RUN;
      boot_q  <= BOOT_INIT;
      lcnt_q  <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      boot_q  <= boot_d;
      lcnt_q  <= lcnt_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      if (stall_pc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    boot_d       = boot_q;
    lcnt_d       = lcnt_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    flush_rem    = '0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    pred_hold    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_q > 3'd1) begin
          boot_d = boot_q - 3'd1;
        end else begin
          boot_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_LSTALL: begin
        if (ext_stall) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          pend_d      = mispredict;
          ret_d       = state_q;
          state_d     = ST_FREEZE;
        end else if (mispredict) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (FLUSH_CYC > 1) begin
            fcnt_d  = FL_M1;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_LSTALL) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          pred_hold    = 1'b1;
          if (lcnt_q > 3'd1) lcnt_d = lcnt_q - 3'd1;
          else               state_d = ST_RUN;
        end else if (hazard) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          pred_hold    = 1'b1;
          if (LOAD_LAT > 1) begin
            lcnt_d  = LAT_M1;
            state_d = ST_LSTALL;
          end
        end
      end
      ST_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        flush_rem   = mispredict ? FL_M1 : (fcnt_q - 2'd1);
        if (flush_rem == '0) state_d = ST_RUN;
        else                 fcnt_d  = flush_rem;
      end
      ST_FREEZE: begin
        // The release cycle drives nothing; the flush or the resumed stall starts next cycle.
        if (ext_stall) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          pend_d      = pend_q | mispredict;
        end else begin
          pend_d = 1'b0;
          if (pend_q || mispredict) begin
            fcnt_d  = FL_FULL;
            state_d = ST_FLUSH;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = RST_ST;
    endcase
  end

  assign state_o     = state_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised scoreboard bench for hazard_ctrl_unit against a counter-based reference model.
module tb_hazard_ctrl_unit;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned NUM_SRC   = 2;
  localparam int unsigned LOAD_LAT  = 3;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned BOOT_CYC  = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     id_ex_mem_read = 1'b0;
  logic [REG_W-1:0]         id_ex_rd = '0;
  logic [NUM_SRC*REG_W-1:0] if_id_rs = '0;
  logic [NUM_SRC-1:0]       if_id_rs_used = '0;
  logic                     mispredict = 1'b0;
  logic                     ext_stall = 1'b0;
  logic                     stall_pc, stall_if_id, bubble_id_ex;
  logic                     flush_if_id, flush_id_ex, pred_hold;
  logic [2:0]               state_o;
  logic [CNT_W-1:0]         stall_count;

  hazard_ctrl_unit #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT),
    .FLUSH_CYC(FLUSH_CYC), .BOOT_CYC(BOOT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used), .mispredict(mispredict),
    .ext_stall(ext_stall), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pred_hold(pred_hold), .state_o(state_o), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       ctl;  // {stall_pc, stall_if_id, bubble, flush_if_id, flush_id_ex, pred_hold}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: remaining-cycle counters instead of an explicit state machine.
  int m_boot = BOOT_CYC, m_stall = 0, m_flush = 0, m_cnt = 0;
  bit m_frozen = 0, m_pend = 0;

  function automatic bit ref_hazard(input bit mr, input logic [REG_W-1:0] rd,
                                    input logic [NUM_SRC*REG_W-1:0] rs,
                                    input logic [NUM_SRC-1:0] used);
    bit h = 0;
    if (!mr || rd == 0) return 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (used[i] && rs[i*REG_W +: REG_W] == rd) h = 1;
    return h;
  endfunction

  task automatic step(input bit r, input bit mr, input logic [REG_W-1:0] rd,
                      input logic [REG_W-1:0] rs0, input logic [REG_W-1:0] rs1,
                      input logic [NUM_SRC-1:0] used, input bit mp, input bit ex);
    exp_t e;
    bit s2 = 0, s4 = 0, fl = 0, hz;
    @(posedge clk);
    #1;
    rst = r; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs = {rs1, rs0};
    if_id_rs_used = used; mispredict = mp; ext_stall = ex;
    hz = ref_hazard(mr, rd, {rs1, rs0}, used);
    if (r) begin
      m_boot = BOOT_CYC; m_stall = 0; m_flush = 0; m_cnt = 0; m_frozen = 0; m_pend = 0;
      e.st = (BOOT_CYC == 0) ? 3'd1 : 3'd0;
    end else begin
      e.st = (m_boot > 0) ? 3'd0 : m_frozen ? 3'd4 : (m_flush > 0) ? 3'd3 : (m_stall > 0) ? 3'd2 : 3'd1;
      if (m_boot > 0) begin
        m_boot--;
      end else if (m_frozen) begin
        if (ex) begin
          s2 = 1; m_pend = m_pend | mp;
        end else begin
          m_frozen = 0;
          if (m_pend || mp) begin m_flush = FLUSH_CYC; m_stall = 0; end
          m_pend = 0;
        end
      end else if (m_flush > 0) begin
        fl = 1;
        m_flush = mp ? FLUSH_CYC - 1 : m_flush - 1;
      end else if (ex) begin
        s2 = 1; m_frozen = 1; m_pend = mp;
      end else if (mp) begin
        fl = 1; m_flush = FLUSH_CYC - 1; m_stall = 0;
      end else if (m_stall > 0) begin
        s4 = 1; m_stall--;
      end else if (hz) begin
        s4 = 1; m_stall = LOAD_LAT - 1;
      end
    end
    e.cnt = CNT_W'(m_cnt);
    e.ctl = {s2 | s4, s2 | s4, s4, fl, fl, s4};
    if (!r && (s2 || s4) && m_cnt < CNT_MAX) m_cnt++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, g;
      e = q.pop_front();
      g.st  = state_o;
      g.cnt = stall_count;
      g.ctl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, pred_hold};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d got st=%0d cnt=%0d ctl=%06b exp st=%0d cnt=%0d ctl=%06b",
                 cyc, g.st, g.cnt, g.ctl, e.st, e.cnt, e.ctl);
      end
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Boot window with a load-use hazard held across reset release.
    step(1, 1, 5, 5, 0, 2'b01, 0, 0);
    step(1, 1, 5, 5, 0, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5, 5, 0, 2'b01, 0, 0);
    idle(4);
    // Single load-use on source 1: LOAD_LAT stall cycles.
    step(0, 1, 5, 0, 5, 2'b10, 0, 0);
    idle(5);
    // x0 never hazards; unused matching source never hazards.
    step(0, 1, 0, 0, 0, 2'b11, 0, 0);
    step(0, 1, 7, 7, 7, 2'b00, 0, 0);
    idle(2);
    // Mispredict in the second stall cycle aborts the stall.
    step(0, 1, 9, 9, 3, 2'b01, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(5);
    // Four-cycle freeze with a mispredict in the second cycle.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // Freeze in the middle of a load stall, then resume it.
    step(0, 1, 4, 4, 4, 2'b11, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // Long hazard to saturate the counter, then async reset in a load stall.
    for (int i = 0; i < 22; i++) step(0, 1, 6, 6, 1, 2'b01, 0, 0);
    step(0, 1, 6, 6, 1, 2'b01, 0, 0);
    step(1, 1, 6, 6, 1, 2'b01, 0, 0);
    idle(5);
    // Random traffic with occasional bursty freezes and rare resets.
    for (int i = 0; i < 500; i++) begin
      bit r, mr, mp, ex;
      r  = ($urandom_range(0, 149) == 0);
      mr = $urandom_range(0, 1);
      mp = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 7) == 0) || (ext_stall && $urandom_range(0, 2) != 0);
      step(r, mr, REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 3)), NUM_SRC'($urandom_range(0, 3)), mp, ex);
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got pending=%0d exp pending=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
